// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_CORES cores.
// One access per grant: IDLE -> BUSY (wait for mem_ready or timeout) -> RELEASE.
module mem_port_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int TIMEOUT   = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        req_we,
    input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
    input  logic [NUM_CORES*DATA_W-1:0] req_wdata,
    output logic [NUM_CORES-1:0]        grant,
    output logic [NUM_CORES-1:0]        done,
    output logic                        err,
    output logic [DATA_W-1:0]           rdata,
    output logic                        busy,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        mem_ready
);
    localparam int IDX_W = $clog2(NUM_CORES);
    localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

    state_t                 state_q, state_d;
    logic [NUM_CORES-1:0]   grant_q, grant_d;
    logic [NUM_CORES-1:0]   done_q, done_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;
    logic                   mem_en_q, mem_en_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [7:0]             cnt_q, cnt_d;

    logic                   hi_vld, lo_vld, sel_vld;
    logic [IDX_W-1:0]       hi_idx, lo_idx, sel_idx;
    logic [NUM_CORES-1:0]   sel_oh;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_wdata;
    logic                   sel_we;

    // Two descending scans: the lowest requester above last wins, else the
    // lowest requester at or below last (wrap-around).
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i > int'(last_q)) begin
                    hi_vld = 1'b1;
                    hi_idx = IDX_W'(i);
                end else begin
                    lo_vld = 1'b1;
                    lo_idx = IDX_W'(i);
                end
            end
        end
    end

    assign sel_vld = hi_vld | lo_vld;
    assign sel_idx = hi_vld ? hi_idx : lo_idx;

    always_comb begin
        sel_oh    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (IDX_W'(i) == sel_idx) begin
                sel_oh[i] = 1'b1;
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_we    = req_we[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = '0;
        err_d       = 1'b0;
        busy_d      = busy_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (sel_vld) begin
                    grant_d     = sel_oh;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    mem_we_d    = sel_we;
                    mem_en_d    = 1'b1;
                    busy_d      = 1'b1;
                    last_d      = sel_idx;
                    cnt_d       = '0;
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                // A ready on the limit cycle still counts as success.
                if (mem_ready) begin
                    if (!mem_we_q) rdata_d = mem_rdata;
                    done_d   = grant_q;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    state_d  = S_RELEASE;
                end else if (cnt_q == CNT_LIMIT) begin
                    if (!mem_we_q) rdata_d = '0;
                    done_d   = grant_q;
                    err_d    = 1'b1;
                    mem_en_d = 1'b0;
                    state_d  = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RELEASE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            last_q      <= IDX_W'(NUM_CORES - 1);
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter sharing one data-memory port (address, write data, read data) among NUM_CORES cores.
- Each core raises a request carrying its AR address, its write data and a write flag. The arbiter grants one core at a time and drives the shared memory port for that core.
- It returns read data (bound for that core's MDDR) or write completion, with a one-cycle done pulse.
- It sits between the per-core AR/MDDR paths and the single shared memory. A wait-state timeout guards against a memory that never responds.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- ADDR_W, 16, memory address width (matches AR).
- DATA_W, 16, memory data width (matches MDDR).
- TIMEOUT, 15, maximum number of BUSY cycles to wait for mem_ready before aborting (1..255).

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_CORES  per-core access request, level; held until the core sees done.
- req_we  in  NUM_CORES  per-core write flag (1=write, 0=read), valid while req=1.
- req_addr  in  NUM_CORES*ADDR_W  per-core address, packed; core i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_CORES*DATA_W  per-core write data, packed the same way.
- grant  out  NUM_CORES  one-hot; identifies the core owning the port.
- done  out  NUM_CORES  one-cycle completion pulse to the granted core.
- err  out  1  one-cycle pulse, coincident with done, when the access timed out.
- rdata  out  DATA_W  read data to the completing core; holds its value until the next completed read.
- busy  out  1  high while in BUSY or RELEASE.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ready=1.
- mem_ready  in  1  memory access complete.

Behaviour:
- Reset values: all outputs 0; state IDLE; wait counter 0; round-robin pointer last = NUM_CORES-1, so core 0 has top priority first.
- State IDLE:
  - If any req bit is set, select the first requesting core scanning last+1, last+2, ... modulo NUM_CORES.
  - At that edge, register grant (one-hot), mem_addr, mem_wdata and mem_we from the selected slice; set mem_en=1 and busy=1; load last with the selected index; clear the counter; go to BUSY.
  - Latency: a req first sampled high at edge k produces grant and mem_en high after edge k.
- State BUSY:
  - mem_en, mem_we, mem_addr and mem_wdata stay stable. Changes on the granted core's req, req_addr, req_wdata or req_we are ignored.
  - If mem_ready=1 at an edge:
    - for a read, rdata <= mem_rdata;
    - done[g] pulses for one cycle;
    - mem_en <= 0 and mem_we <= 0;
    - go to RELEASE.
  - Otherwise the counter increments. When the counter equals TIMEOUT-1 and mem_ready=0:
    - done[g] and err pulse together;
    - rdata <= 0 for a read (unchanged for a write);
    - mem_en <= 0;
    - go to RELEASE.
  - A mem_ready on the same edge as the timeout limit counts as success; err stays 0.
- State RELEASE:
  - Lasts one cycle. grant <= 0, busy <= 0 at exit; go to IDLE.
  - Gives the completing core one cycle to drop req. A req still high from that core in IDLE is treated as a new request.
- Fairness:
  - The core just served has lowest priority at the next arbitration.
  - With all cores requesting continuously, the grant order is 0,1,2,3,0,...
  - Each access costs at least 3 cycles: IDLE, BUSY, RELEASE.
- Request withdrawn during BUSY (req dropped): the access still completes and done still pulses; there is no abort.
- Unrequested cores never see done.
- mem_en is never high outside BUSY, and grant is never multi-hot.
- Reset asserted mid-access: immediate return to reset values. The in-flight access is abandoned with no done pulse. mem_en drops asynchronously.

Test Plan:
- Single read: reset, then core 1 req=1, we=0, addr=0x0040; mem_ready one cycle after mem_en with mem_rdata=0xBEEF -> grant=0010 one cycle after req, mem_addr=0x0040, done[1] pulse, rdata=0xBEEF, err=0, back to IDLE 3 cycles after grant.
- Write: core 0 req_we=1, addr=0x0100, wdata=0x1234 -> mem_we=1, mem_wdata=0x1234 throughout BUSY, done[0] pulse, rdata unchanged.
- Round robin: all 4 cores request continuously, mem_ready immediate -> grant sequence 0001, 0010, 0100, 1000, 0001, with a grant every 3 cycles.
- Timeout: TIMEOUT=15, mem_ready held 0 on a read -> done and err pulse after 15 BUSY cycles, rdata=0x0000, mem_en low the next cycle.
- Simultaneous ready and timeout: mem_ready=1 exactly at the 15th BUSY cycle with mem_rdata=0x00AA -> err=0, rdata=0x00AA.
- Reset mid-BUSY: Reset_n low for 1 cycle during a core 2 read -> grant=0, mem_en=0 immediately, no done pulse; next arbitration with cores 2 and 3 requesting grants core 0 priority first (core 2 when only 2 and 3 request).
